// File: rtl/cache_controller.sv
// cache_controller: MEM-stage front end for a 2-way data cache and an SRAM controller.
// Loads hit with zero added latency or fill a 64-bit line; stores write through without allocating.
module cache_controller #(
   parameter logic [31:0] BASE_ADDR    = 32'd1024,
   parameter int          CACHE_ADDR_W = 19
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             address,
   input  logic [31:0]             wdata,
   input  logic                    MEM_R_EN,
   input  logic                    MEM_W_EN,
   output logic [31:0]             rdata,
   output logic                    ready,
   output logic [CACHE_ADDR_W-1:0] cache_addr,
   output logic                    cache_R_EN,
   output logic                    cache_W_EN,
   output logic [63:0]             cache_wdata,
   output logic                    cache_invalidate,
   input  logic                    cache_hit,
   input  logic [31:0]             cache_rdata,
   output logic [CACHE_ADDR_W-1:0] sram_address,
   output logic [31:0]             sram_wdata,
   output logic                    sram_R_EN,
   output logic                    sram_W_EN,
   input  logic [63:0]             sram_rdata,
   input  logic                    sram_ready
);
   localparam logic [1:0] IDLE = 2'd0, READ_MISS = 2'd1, WRITE = 2'd2;

   logic [1:0]              state, state_nxt;
   logic [31:0]             eff, wdata_q, rdata_q;
   logic [CACHE_ADDR_W-1:0] addr_q;
   logic                    idle, wr_req, rd_req, hit_rd, miss_start, miss_done, unused_hi;

   assign eff       = address - BASE_ADDR;
   assign unused_hi = ^eff[31:CACHE_ADDR_W];
   assign idle      = (state == IDLE);
   // requests are masked while reset is held so no strobe escapes during reset
   assign wr_req     = idle & rst & MEM_W_EN;
   assign rd_req     = idle & rst & MEM_R_EN & ~MEM_W_EN;
   assign hit_rd     = rd_req & cache_hit;
   assign miss_start = rd_req & ~cache_hit;
   assign miss_done  = (state == READ_MISS) & sram_ready;

   assign cache_addr       = idle ? eff[CACHE_ADDR_W-1:0] : addr_q;
   assign sram_address     = cache_addr;
   assign cache_R_EN       = hit_rd;
   assign cache_W_EN       = miss_done;
   assign cache_wdata      = sram_rdata;
   assign cache_invalidate = wr_req;
   assign sram_wdata       = wdata_q;
   assign sram_R_EN        = (state == READ_MISS);
   assign sram_W_EN        = (state == WRITE);
   assign ready            = idle ? ~(wr_req | miss_start) : sram_ready;
   assign rdata            = hit_rd ? cache_rdata :
                             miss_done ? (addr_q[2] ? sram_rdata[63:32] : sram_rdata[31:0]) : rdata_q;

   always_comb
      state_nxt = idle ? (wr_req ? WRITE : miss_start ? READ_MISS : IDLE) :
                  ((state == READ_MISS || state == WRITE) && !sram_ready) ? state : IDLE;

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_nxt;
         rdata_q <= rdata;
         if (wr_req | miss_start) addr_q <= eff[CACHE_ADDR_W-1:0];
         if (wr_req) wdata_q <= wdata;
      end
endmodule
